ram_queue_executor: RTL

- Consumer end of the control unit's instruction queue; the control unit is the writer.
- Pops queued RAM instructions and moves one tile of TILE_ROWS rows between main memory and cache.
- Row addresses are generated from the queued base and stride (cache_addr/d_cache_addr, main_mem_addr/d_main_mem_addr).
- Sits between the queue FIFO, the cache row port and the main-memory request port.

---
 rtl/ram_queue_executor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ram_queue_executor.sv
// Instruction-queue consumer: pops RAM entries and moves one tile of TILE_ROWS rows between main memory and cache.
// Optional build macro RAM_QUEUE_EXECUTOR_PERF_EN adds saturating perf_rows / perf_stall counters.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for a queue entry; pops and decodes the head
// S_MEM_REQ   | main-memory request held until mem_ack (read or write)
// S_CACHE_WR  | writes the row captured from main memory into the cache
// S_CACHE_RD  | issues a cache row read (data arrives next cycle)
// S_CACHE_CAP | captures cache_rdata for the upcoming memory write
// S_NEXT      | advances address sums and row counter; ends after last row
module ram_queue_executor #(
    parameter int          ADDR_W         = 18,
    parameter int          ROW_BITS       = 64,
    parameter int          TILE_ROWS      = 4,
    parameter logic [1:0]  INSTR_TYPE_RAM = 2'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                queue_empty,
    output logic                queue_re,
    input  logic [1:0]          queue_instr_type,
    input  logic                queue_is_write,
    input  logic [ADDR_W-1:0]   q_cache_addr,
    input  logic [ADDR_W-1:0]   q_main_mem_addr,
    input  logic [ADDR_W-1:0]   q_d_cache_addr,
    input  logic [ADDR_W-1:0]   q_d_main_mem_addr,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [ROW_BITS-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [ROW_BITS-1:0] mem_rdata,
    output logic                cache_re,
    output logic                cache_we,
    output logic [ADDR_W-1:0]   cache_addr_o,
    output logic [ROW_BITS-1:0] cache_wdata,
    input  logic [ROW_BITS-1:0] cache_rdata,
    output logic                busy,
    output logic                bad_instr
`ifdef RAM_QUEUE_EXECUTOR_PERF_EN
    ,
    output logic [31:0]         perf_rows,
    output logic [31:0]         perf_stall
`endif
);

    localparam int ROW_W = (TILE_ROWS > 2) ? $clog2(TILE_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE_ROWS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MEM_REQ   = 3'd1;
    localparam logic [2:0] S_CACHE_WR  = 3'd2;
    localparam logic [2:0] S_CACHE_RD  = 3'd3;
    localparam logic [2:0] S_CACHE_CAP = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                r_alive;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_cache_sum;
    logic [ADDR_W-1:0]   r_main_sum;
    logic [ADDR_W-1:0]   r_d_cache;
    logic [ADDR_W-1:0]   r_d_main;
    logic [ROW_W-1:0]    r_row;
    logic [ROW_BITS-1:0] r_data;

    logic w_pop;
    logic w_is_ram;
    logic w_last_row;

    // r_alive keeps queue_re low while reset is held, even with a non-empty queue
    assign w_pop      = r_alive && (r_state == S_IDLE) && !queue_empty;
    assign w_is_ram   = (queue_instr_type == INSTR_TYPE_RAM);
    assign w_last_row = (r_row == LAST_ROW);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop && w_is_ram) begin
                    w_state_nxt = queue_is_write ? S_CACHE_RD : S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mem_ack) begin
                    w_state_nxt = r_is_write ? S_NEXT : S_CACHE_WR;
                end
            end
            S_CACHE_WR:  w_state_nxt = S_NEXT;
            S_CACHE_RD:  w_state_nxt = S_CACHE_CAP;
            S_CACHE_CAP: w_state_nxt = S_MEM_REQ;
            S_NEXT: begin
                if (w_last_row) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_is_write ? S_CACHE_RD : S_MEM_REQ;
                end
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    // Address sums replace i*stride: each NEXT adds one stride, wrapping mod 2^ADDR_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_write  <= 1'b0;
            r_cache_sum <= '0;
            r_main_sum  <= '0;
            r_d_cache   <= '0;
            r_d_main    <= '0;
            r_row       <= '0;
        end else if (w_pop) begin
            r_is_write  <= queue_is_write;
            r_cache_sum <= q_cache_addr;
            r_main_sum  <= q_main_mem_addr;
            r_d_cache   <= q_d_cache_addr;
            r_d_main    <= q_d_main_mem_addr;
            r_row       <= '0;
        end else if (r_state == S_NEXT) begin
            r_cache_sum <= r_cache_sum + r_d_cache;
            r_main_sum  <= r_main_sum + r_d_main;
            r_row       <= r_row + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if ((r_state == S_MEM_REQ) && mem_ack && !r_is_write) begin
            r_data <= mem_rdata;
        end else if (r_state == S_CACHE_CAP) begin
            r_data <= cache_rdata;
        end
    end

    assign queue_re     = w_pop;
    assign bad_instr    = w_pop && !w_is_ram;
    assign busy         = (r_state != S_IDLE);
    assign mem_req      = (r_state == S_MEM_REQ);
    assign mem_we       = mem_req && r_is_write;
    assign mem_addr     = r_main_sum;
    assign mem_wdata    = r_data;
    assign cache_re     = (r_state == S_CACHE_RD);
    assign cache_we     = (r_state == S_CACHE_WR);
    assign cache_addr_o = r_cache_sum;
    assign cache_wdata  = r_data;

`ifdef RAM_QUEUE_EXECUTOR_PERF_EN
    logic [31:0] r_perf_rows;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_rows  <= '0;
            r_perf_stall <= '0;
        end else begin
            if ((r_state == S_NEXT) && (r_perf_rows != '1)) begin
                r_perf_rows <= r_perf_rows + 32'd1;
            end
            if (mem_req && !mem_ack && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_rows  = r_perf_rows;
    assign perf_stall = r_perf_stall;
`endif

endmodule
